fetch_unit: RTL and testbench

Instruction fetch stage of the uRISC pipeline and the producer of the IF/ID interface that decode consumes (inst_ifid_p1, valid, PC). It keeps the PC, issues 16-bit instruction reads to instruction memory, buffers returned words in a small FIFO and presents them to decode under decode's stall. Redirects from later stages flush it, and a HALT (opcode 5'b00000) delivered to decode stops fetching.

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : uRISC instruction fetch stage, producer of the IF/ID interface.
// Rev 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_p1,
  output logic [15:0] imem_addr_p1,
  input  logic        imem_gnt,
  input  logic        imem_rsp_vld,
  input  logic [15:0] imem_rsp_data,
  input  logic        stall_id,
  input  logic        redirect_vld,
  input  logic [15:0] redirect_pc,
  output logic [15:0] inst_ifid_p1,
  output logic [15:0] pc_ifid_p1,
  output logic        inst_vld_ifid_p1,
  output logic        halted_p1
);
  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [15:0] NOP = 16'h0800;

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [OW-1:0] drop_q, drop_d;
  logic          halted_q, halted_d;
  logic          post_rst_q, post_rst_d;
  logic [QW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] thead_q, thead_d, ttail_q, ttail_d;
  logic [15:0]   qinst_q [QDEPTH];
  logic [15:0]   qpc_q   [QDEPTH];
  logic [15:0]   tag_q   [MAX_OUT];

  logic hs, rsp, keep, pop, halt_pop;
  logic unused_bits;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  // Credits: a request is only issued when its response is sure to find a slot.
  assign imem_req_p1 = !rst && !halted_q && !redirect_vld &&
                       (out_cnt_q < OW'(MAX_OUT)) &&
                       ((int'(cnt_q) + int'(out_cnt_q)) < QDEPTH);
  assign imem_addr_p1 = fetch_pc_q;
  assign unused_bits  = redirect_pc[0];

  assign hs       = imem_req_p1 && imem_gnt;
  assign rsp      = imem_rsp_vld && (out_cnt_q != '0);
  assign keep     = rsp && (drop_q == '0);
  assign pop      = inst_vld_ifid_p1 && !stall_id;
  assign halt_pop = pop && (qinst_q[head_q][15:11] == 5'b00000);

  assign inst_vld_ifid_p1 = (cnt_q != '0) && !halted_q;
  assign inst_ifid_p1     = inst_vld_ifid_p1 ? qinst_q[head_q] : NOP;
  assign pc_ifid_p1       = inst_vld_ifid_p1 ? qpc_q[head_q] : 16'h0000;
  assign halted_p1        = halted_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    post_rst_d = post_rst_q && !hs;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    thead_d    = thead_q;
    ttail_d    = ttail_q;

    if (hs) begin
      fetch_pc_d = fetch_pc_q + 16'd2;
      ttail_d    = tag_next(ttail_q);
    end
    if (rsp) thead_d = tag_next(thead_q);
    out_cnt_d = out_cnt_q + OW'(hs) - OW'(rsp);
    if (rsp && (drop_q != '0)) drop_d = drop_q - OW'(1);
    if (keep) tail_d = tail_q + QW'(1);
    if (pop)  head_d = head_q + QW'(1);
    cnt_d = cnt_q + CW'(keep) - CW'(pop);

    // Everything still in flight after a HALT or redirect belongs to a dead path.
    if (halt_pop) begin
      halted_d = 1'b1;
      head_d   = '0;
      tail_d   = '0;
      cnt_d    = '0;
      drop_d   = out_cnt_d;
    end
    if (redirect_vld) begin
      fetch_pc_d = {redirect_pc[15:1], 1'b0};
      halted_d   = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      cnt_d      = '0;
      drop_d     = out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      drop_q     <= '0;
      halted_q   <= 1'b0;
      post_rst_q <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      thead_q    <= '0;
      ttail_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
      post_rst_q <= post_rst_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      thead_q    <= thead_d;
      ttail_q    <= ttail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      qinst_q[tail_q] <= imem_rsp_data;
      qpc_q[tail_q]   <= tag_q[thead_q];
    end
    if (hs) tag_q[ttail_q] <= fetch_pc_q;
  end

  // Leftover responses from before a reset are tolerated until fetch restarts.
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_vld && (out_cnt_q == '0) && !post_rst_q));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : randomized scoreboard bench for fetch_unit.
// Rev 1.0
// ============================================================================
module tb_fetch_unit;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_p1;
  logic [15:0] imem_addr_p1;
  logic        imem_gnt;
  logic        imem_rsp_vld;
  logic [15:0] imem_rsp_data;
  logic        stall_id;
  logic        redirect_vld;
  logic [15:0] redirect_pc;
  logic [15:0] inst_ifid_p1;
  logic [15:0] pc_ifid_p1;
  logic        inst_vld_ifid_p1;
  logic        halted_p1;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(4), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_p1(imem_req_p1), .imem_addr_p1(imem_addr_p1), .imem_gnt(imem_gnt),
    .imem_rsp_vld(imem_rsp_vld), .imem_rsp_data(imem_rsp_data),
    .stall_id(stall_id), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .inst_ifid_p1(inst_ifid_p1), .pc_ifid_p1(pc_ifid_p1),
    .inst_vld_ifid_p1(inst_vld_ifid_p1), .halted_p1(halted_p1)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] pc; logic [15:0] inst; } item_t;
  typedef struct { logic [15:0] data; int due; } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          delivered = 0;
  bit          halted_exp = 1'b0;
  logic [15:0] exp_fetch = RESET_PC;
  item_t       exp_q[$];
  rsp_t        mem_pipe[$];
  logic [15:0] mem_ovr [logic [15:0]];

  // Program image: fixed words at the bottom of memory, a hash elsewhere that never encodes HALT.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] h;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    h = (a * 16'h9E37) ^ 16'h5A5A;
    if (h[15:11] == 5'b00000) h[15:11] = 5'b10101;
    return h;
  endfunction

  // Decode must see the sequential program from start up to and including the first HALT.
  function automatic void load_stream(input logic [15:0] start);
    logic [15:0] p;
    logic [15:0] w;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      w = mem_word(p);
      exp_q.push_back({p, w});
      if (w[15:11] == 5'b00000) break;
      p = p + 16'd2;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect_vld = 1'b1;
    redirect_pc  = pc;
    exp_fetch    = {pc[15:1], 1'b0};
    load_stream({pc[15:1], 1'b0});
    @(posedge clk); #1;
    redirect_vld = 1'b0;
  endtask

  task automatic do_reset(input int n, input logic g, input logic s);
    rst = 1'b1; redirect_vld = 1'b0; imem_gnt = 1'b0; stall_id = s;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req_p1, 0);
    chk("rst_vld", inst_vld_ifid_p1, 0);
    chk("rst_inst", inst_ifid_p1, 16'h0800);
    chk("rst_pc", pc_ifid_p1, 0);
    chk("rst_halted", halted_p1, 0);
    @(posedge clk); #1;
    exp_fetch = RESET_PC;
    load_stream(RESET_PC);
    rst = 1'b0;
    // Let pre-reset responses land while nothing new is requested.
    for (int i = 0; i < 20 && mem_pipe.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (mem_pipe.size() != 0) chk("stray_drain_timeout", mem_pipe.size(), 0);
    imem_gnt = g;
  endtask

  // Memory: in-order responses, each due a fixed latency after its grant cycle.
  initial begin : memory
    rsp_t r;
    imem_rsp_vld = 1'b0; imem_rsp_data = 16'h0000;
    forever begin
      @(posedge clk); cyc++; #1;
      if (mem_pipe.size() != 0 && mem_pipe[0].due <= cyc) begin
        r = mem_pipe.pop_front();
        imem_rsp_vld = 1'b1; imem_rsp_data = r.data;
      end else begin
        imem_rsp_vld = 1'b0; imem_rsp_data = 16'($urandom);
      end
    end
  end

  initial begin : monitor
    item_t it;
    int    d;
    forever begin
      @(negedge clk);
      if (rst) begin
        halted_exp = 1'b0;
        continue;
      end
      chk("halted", halted_p1, halted_exp);
      if (halted_exp) chk("req_while_halted", imem_req_p1, 0);
      if (redirect_vld) chk("req_in_redirect", imem_req_p1, 0);
      if (!inst_vld_ifid_p1) chk("nop_when_invalid", inst_ifid_p1, 16'h0800);
      if (imem_req_p1 && imem_gnt) begin
        chk("fetch_addr", imem_addr_p1, exp_fetch);
        exp_fetch = exp_fetch + 16'd2;
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mem_pipe.push_back('{data: mem_word(imem_addr_p1), due: d});
      end
      if (redirect_vld) begin
        halted_exp = 1'b0;
      end else if (inst_vld_ifid_p1 && !stall_id) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_inst: got pc %h inst %h, required no instruction", pc_ifid_p1, inst_ifid_p1);
        end else begin
          it = exp_q.pop_front();
          chk("deliver_pc", pc_ifid_p1, it.pc);
          chk("deliver_inst", inst_ifid_p1, it.inst);
          delivered++;
          if (it.inst[15:11] == 5'b00000) halted_exp = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    int          d0;
    int          r;
    bit          found;
    logic [15:0] pc;
    rst = 1'b1; imem_gnt = 1'b0; stall_id = 1'b0; redirect_vld = 1'b0; redirect_pc = 16'h0000;
    mem_ovr[16'h0000] = 16'h481F;
    mem_ovr[16'h0002] = 16'hA81F;
    mem_ovr[16'h0004] = 16'h8810;
    mem_ovr[16'h0006] = 16'h0000;

    // Back-to-back fetch, latency 1, then HALT at 0x0006.
    lat = 1;
    do_reset(3, 1'b1, 1'b0);
    @(negedge clk);
    chk("c0_req", imem_req_p1, 1);
    chk("c0_addr", imem_addr_p1, 16'h0000);
    chk("c0_vld", inst_vld_ifid_p1, 0);
    @(negedge clk);
    chk("c1_vld", inst_vld_ifid_p1, 0);
    @(negedge clk);
    chk("c2_vld", inst_vld_ifid_p1, 1);
    chk("c2_pc", pc_ifid_p1, 16'h0000);
    chk("c2_inst", inst_ifid_p1, 16'h481F);
    repeat (10) @(negedge clk);
    chk("halt_state", halted_p1, 1);
    chk("halt_vld", inst_vld_ifid_p1, 0);
    chk("halt_inst", inst_ifid_p1, 16'h0800);
    chk("halt_req", imem_req_p1, 0);
    @(posedge clk); #1;
    do_redirect(16'h0020);
    repeat (10) @(posedge clk);
    #1;

    // Decode stalled from reset: queue fills, requests stop at 0x0008.
    do_reset(2, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("stall_req", imem_req_p1, 0);
    chk("stall_addr", imem_addr_p1, 16'h0008);
    chk("stall_vld", inst_vld_ifid_p1, 1);
    chk("stall_head_pc", pc_ifid_p1, 16'h0000);
    @(posedge clk); #1;
    d0 = delivered;
    stall_id = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("drain_4_in_4", delivered - d0, 4);
    repeat (6) @(posedge clk);
    #1;

    // Redirect with two requests outstanding at latency 3.
    lat = 3;
    do_redirect(16'h0200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_redirect(16'h0101);
    repeat (20) @(posedge clk);
    #1;

    // Redirect in the very cycle the HALT word is dequeued.
    lat = 1;
    do_redirect(16'h0000);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (inst_vld_ifid_p1 && inst_ifid_p1[15:11] == 5'b00000) begin
        found = 1'b1;
        break;
      end
    end
    chk("halt_head_seen", found, 1);
    stall_id = 1'b0;
    do_redirect(16'h0040);
    @(negedge clk);
    chk("redirect_beats_halt", halted_p1, 0);
    repeat (15) @(posedge clk);
    #1;

    // Reset in the middle of a latency-3 stream.
    lat = 3;
    do_redirect(16'h0300);
    repeat (8) @(posedge clk);
    #1;
    do_reset(1, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    // Random traffic: grants, stalls, latencies, redirects and resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      r = $urandom_range(0, 999);
      if (r < 4) begin
        lat = $urandom_range(1, 4);
        do_reset($urandom_range(1, 3), 1'b1, 1'b0);
      end else if (r < 35) begin
        lat = $urandom_range(1, 4);
        pc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
        do_redirect(pc);
      end else begin
        imem_gnt = ($urandom_range(0, 99) < 70);
        stall_id = ($urandom_range(0, 99) < 30);
      end
    end
    imem_gnt = 1'b1; stall_id = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("enough_traffic", delivered > 300, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
